press_emitter: RTL and testbench



---
 rtl/press_emitter.sv | 108 ++++++++++
 tb/tb_press_emitter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/press_emitter.sv
// Turns single-cycle press requests into a rate-limited pulse train: HIGH_N cycles high,
// then at least LOW_N cycles low. Requests that arrive mid-pulse queue in a saturating counter.
module press_emitter #(
    parameter int HIGH_N   = 7,
    parameter int LOW_N    = 7,
    parameter int PEND_MAX = 3,
    localparam int PEND_BIT = $clog2(PEND_MAX + 1),
    localparam int CNT_MAX  = (HIGH_N > LOW_N) ? HIGH_N : LOW_N,
    localparam int CNT_BIT  = $clog2(CNT_MAX + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_press,
    output logic                o_out,
    output logic                o_busy,
    output logic [PEND_BIT-1:0] o_pend,
    output logic                o_done,
    output logic                o_drop
);
    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

    localparam logic [CNT_BIT-1:0]  HIGH_LD   = CNT_BIT'(HIGH_N - 1);
    localparam logic [CNT_BIT-1:0]  LOW_LD    = CNT_BIT'(LOW_N - 1);
    localparam logic [PEND_BIT-1:0] PEND_FULL = PEND_BIT'(PEND_MAX);

    state_t              state_q, state_d;
    logic [CNT_BIT-1:0]  cnt_q, cnt_d;
    logic [PEND_BIT-1:0] pend_q, pend_d;
    logic                out_q, done_q, drop_q, drop_d;
    logic                inc, dec;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inc     = 1'b0;
        dec     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A live press takes priority; pending is only drawn on when no press is present.
                if (i_press || pend_q != '0) begin
                    state_d = S_HIGH;
                    cnt_d   = HIGH_LD;
                    dec     = !i_press;
                end
            end
            S_HIGH: begin
                inc = i_press;
                if (cnt_q == '0) begin
                    state_d = S_LOW;
                    cnt_d   = LOW_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_LOW: begin
                if (cnt_q != '0) begin
                    inc   = i_press;
                    cnt_d = cnt_q - 1'b1;
                end else if (pend_q != '0) begin
                    // Oldest queued request goes first; a same-cycle press takes its slot.
                    dec     = 1'b1;
                    inc     = i_press;
                    state_d = S_HIGH;
                    cnt_d   = HIGH_LD;
                end else if (i_press) begin
                    state_d = S_HIGH;
                    cnt_d   = HIGH_LD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pend_d = pend_q;
        drop_d = 1'b0;
        if (inc && !dec) begin
            if (pend_q == PEND_FULL) drop_d = 1'b1;
            else                     pend_d = pend_q + 1'b1;
        end else if (dec && !inc && pend_q != '0) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            out_q   <= (state_d == S_HIGH);
            done_q  <= (state_d == S_LOW) && (cnt_d == '0);
            drop_q  <= drop_d;
        end
    end

    assign o_out  = out_q;
    assign o_done = done_q;
    assign o_drop = drop_q;
    assign o_pend = pend_q;
    assign o_busy = (state_q != S_IDLE) || (pend_q != '0);
endmodule

// File: tb/tb_press_emitter.sv
// Bench for press_emitter: three instances (3/2/3, defaults, 1/1/1); expected done/drop
// events are queued by the stimulus and matched by an independent monitor.
module tb_press_emitter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]      rst, press;
    wire  [2:0]      out_a, busy_a, done_a, drop_a;
    wire  [2:0][1:0] pend_a;

    press_emitter #(.HIGH_N(3), .LOW_N(2), .PEND_MAX(3)) u0 (
        .i_clk(clk), .i_rst(rst[0]), .i_press(press[0]), .o_out(out_a[0]), .o_busy(busy_a[0]),
        .o_pend(pend_a[0]), .o_done(done_a[0]), .o_drop(drop_a[0]));
    press_emitter u1 (
        .i_clk(clk), .i_rst(rst[1]), .i_press(press[1]), .o_out(out_a[1]), .o_busy(busy_a[1]),
        .o_pend(pend_a[1]), .o_done(done_a[1]), .o_drop(drop_a[1]));
    press_emitter #(.HIGH_N(1), .LOW_N(1), .PEND_MAX(1)) u2 (
        .i_clk(clk), .i_rst(rst[2]), .i_press(press[2]), .o_out(out_a[2]), .o_busy(busy_a[2]),
        .o_pend(pend_a[2][0]), .o_done(done_a[2]), .o_drop(drop_a[2]));
    assign pend_a[2][1] = 1'b0;

    typedef struct {
        int inst;
        int kind;   // 0 = done, 1 = drop
        int cy;
        int pend;
        int hi;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;
    int  hi_run[3];
    int  last_hi[3];

    task automatic push(input int inst, input int kind, input int cy, input int pend, input int hi);
        ev_t e;
        e.inst = inst; e.kind = kind; e.cy = cy; e.pend = pend; e.hi = hi;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic match(input int k, input int kind);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event u%0d kind %0d at cycle %0d pend %0d", k, kind, cyc, pend_a[k]);
        end else begin
            e = exp_q.pop_front();
            if (e.inst != k || e.kind != kind || e.cy != cyc || e.pend != int'(pend_a[k]) ||
                (kind == 0 && e.hi != last_hi[k])) begin
                n_fail++;
                $display("FAIL event u%0d kind %0d: got cyc %0d pend %0d hi %0d, expected u%0d kind %0d cyc %0d pend %0d hi %0d",
                         k, kind, cyc, pend_a[k], last_hi[k], e.inst, e.kind, e.cy, e.pend, e.hi);
            end
        end
    endtask

    // Monitor: tracks the length of each high run and pops one expectation per done/drop pulse.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (out_a[k] === 1'b1) hi_run[k]++;
            else if (hi_run[k] != 0) begin
                last_hi[k] = hi_run[k];
                hi_run[k]  = 0;
            end
            if (done_a[k] === 1'b1) match(k, 0);
            if (drop_a[k] === 1'b1) match(k, 1);
        end
    end

    task automatic drain(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int c;
        int hc;
        for (int k = 0; k < 3; k++) begin
            hi_run[k]  = 0;
            last_hi[k] = 0;
        end
        rst   = 3'b111;
        press = 3'b111;
        repeat (2) @(negedge clk);
        rst   = 3'b000;
        press = 3'b000;
        for (int k = 0; k < 3; k++) begin
            chk("rst_out",  out_a[k],  0);
            chk("rst_pend", pend_a[k], 0);
            chk("rst_done", done_a[k], 0);
            chk("rst_drop", drop_a[k], 0);
            chk("rst_busy", busy_a[k], 0);
        end
        @(negedge clk);
        chk("rst_press_ignored", busy_a, 0);

        // Single press, 3 high / 2 low.
        c = cyc;
        press[0] = 1'b1;
        push(0, 0, c + 5, 0, 3);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            press[0] = 1'b0;
            chk("single_out", out_a[0], (k <= 3) ? 1 : 0);
            if (k == 5) chk("single_busy_hi", busy_a[0], 1);
            if (k == 6) chk("single_busy_lo", busy_a[0], 0);
        end
        drain(20);

        // Burst of four presses, default timing.
        c = cyc;
        press[1] = 1'b1;
        push(1, 0, c + 14, 3, 7);
        push(1, 0, c + 28, 2, 7);
        push(1, 0, c + 42, 1, 7);
        push(1, 0, c + 56, 0, 7);
        repeat (4) @(negedge clk);
        press[1] = 1'b0;
        chk("burst_pend", pend_a[1], 3);
        drain(100);

        // Overflow: six presses, two rejected.
        c = cyc;
        press[1] = 1'b1;
        push(1, 1, c + 5, 3, 0);
        push(1, 1, c + 6, 3, 0);
        push(1, 0, c + 14, 3, 7);
        push(1, 0, c + 28, 2, 7);
        push(1, 0, c + 42, 1, 7);
        push(1, 0, c + 56, 0, 7);
        repeat (6) @(negedge clk);
        press[1] = 1'b0;
        drain(100);

        // Press on the last low cycle with a full queue: inc and dec cancel.
        c = cyc;
        press[1] = 1'b1;
        push(1, 0, c + 14, 3, 7);
        push(1, 0, c + 28, 3, 7);
        push(1, 0, c + 42, 2, 7);
        push(1, 0, c + 56, 1, 7);
        push(1, 0, c + 70, 0, 7);
        repeat (4) @(negedge clk);
        press[1] = 1'b0;
        repeat (10) @(negedge clk);
        chk("incdec_done_now", done_a[1], 1);
        press[1] = 1'b1;
        @(negedge clk);
        press[1] = 1'b0;
        chk("incdec_pend", pend_a[1], 3);
        chk("incdec_out",  out_a[1],  1);
        chk("incdec_drop", drop_a[1], 0);
        drain(100);

        // Reset mid-HIGH with two queued.
        c = cyc;
        press[1] = 1'b1;
        repeat (3) @(negedge clk);
        press[1] = 1'b0;
        chk("midrst_pend_before", pend_a[1], 2);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        chk("midrst_out",  out_a[1],  0);
        chk("midrst_pend", pend_a[1], 0);
        chk("midrst_busy", busy_a[1], 0);
        hc = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_a[1]) hc++;
        end
        chk("midrst_quiet", hc, 0);

        // Minimum timing, one-deep queue, press held six cycles.
        c = cyc;
        press[2] = 1'b1;
        push(2, 0, c + 2, 1, 1);
        push(2, 0, c + 4, 1, 1);
        push(2, 1, c + 4, 1, 0);
        push(2, 0, c + 6, 1, 1);
        push(2, 1, c + 6, 1, 0);
        push(2, 0, c + 8, 0, 1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 6) press[2] = 1'b0;
            chk("min_toggle", out_a[2], k % 2);
        end
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
